// File: rtl/prod_accumulator.sv
// prod_accumulator
// Accumulates a frame of unsigned 16-bit products into a saturating ACC_W-bit
// sum and presents the sum, the term count and a sticky overflow flag on a
// valid/ready result port. While a result is pending the input is stalled.
// Parameter constraints: ACC_W >= 16 and 2**CNT_W > MAX_TERMS.

module prod_accumulator #(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [0:0]       ST_ACCUM = 1'b0;
    localparam logic [0:0]       ST_HOLD  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TERMS);

    // Saturating add: returns {overflow, sum}. The add is done one bit wider
    // than the accumulator so the carry-out directly flags saturation; once
    // the accumulator is all ones any non-zero product keeps it there.
    function automatic logic [ACC_W:0] sat_add(
        input logic [ACC_W-1:0] acc,
        input logic [15:0]      prod
    );
        logic [ACC_W:0] wide;
        wide = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
        if (wide[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = wide;
        end
    endfunction

    logic [0:0]       state_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;

    logic             accept_s;
    logic             close_s;
    logic [ACC_W:0]   add_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;

    // Ready depends only on state (and reset), never on in_valid.
    assign in_ready = (state_r == ST_ACCUM) && !rst;
    assign accept_s = in_valid && in_ready;

    // Next accumulator / count / overflow values and frame-close decision.
    always_comb begin
        add_s     = sat_add(acc_r, in_prod);
        acc_nxt_s = add_s[ACC_W-1:0];
        ovf_nxt_s = ovf_r | add_s[ACC_W];
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (accept_s) begin
            close_s = in_last || (cnt_nxt_s == CNT_MAX);
        end else begin
            close_s = 1'b0;
        end
    end

    // Frame state machine, accumulator and registered result port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_ACCUM;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= {ACC_W{1'b0}};
            out_count <= {CNT_W{1'b0}};
            out_ovf   <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_r <= acc_nxt_s;
                        cnt_r <= cnt_nxt_s;
                        ovf_r <= ovf_nxt_s;
                        if (close_s) begin
                            out_sum   <= acc_nxt_s;
                            out_count <= cnt_nxt_s;
                            out_ovf   <= ovf_nxt_s;
                            out_valid <= 1'b1;
                            state_r   <= ST_HOLD;
                        end else begin
                            state_r   <= ST_ACCUM;
                        end
                    end else begin
                        state_r <= ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    // Result fields stay put after the handshake; only
                    // out_valid drops and the frame state is cleared.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc_r     <= {ACC_W{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                        ovf_r     <= 1'b0;
                        state_r   <= ST_ACCUM;
                    end else begin
                        state_r   <= ST_HOLD;
                    end
                end
                default: begin
                    state_r   <= ST_ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
